// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath constants: serial FSM state encoding and default operand width.
package arith_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/full_subtractor.sv
// 1-bit full-subtractor cell built from gate primitives; purely combinational.
module full_subtractor (
  output logic bout,
  output logic diff,
  input  logic a,
  input  logic b,
  input  logic bin
);

  wire a_x_b;
  wire not_a;
  wire not_axb;
  wire gen_brw;
  wire prop_brw;

  xor g_x1 (a_x_b, a, b);
  xor g_x2 (diff, a_x_b, bin);
  not g_n1 (not_a, a);
  and g_a1 (gen_brw, not_a, b);
  not g_n2 (not_axb, a_x_b);
  and g_a2 (prop_brw, not_axb, bin);
  or  g_o1 (bout, gen_brw, prop_brw);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b-bin, result with a done pulse WIDTH+1 cycles after start; start ignored while busy.
// SERIAL_SUBTRACTOR_OVF_EN adds a registered signed-overflow output 'ovf'.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic             brw;
  logic             d_bit;
  logic             brw_nxt;
  logic             accept;

  full_subtractor u_cell (
    .bout (brw_nxt),
    .diff (d_bit),
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (brw)
  );

  // The DONE cycle doubles as an accept slot so back-to-back ops need no idle gap.
  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic a_msb;
  logic b_msb;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (state != ST_SHIFT) begin
      if (accept) begin
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end
    end else if (cnt == LAST) begin
      ovf <= (a_msb != b_msb) && (d_bit != a_msb);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      d_sh  <= '0;
      brw   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          d_sh <= {d_bit, d_sh[WIDTH-1:1]};
          brw  <= brw_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            diff  <= {d_bit, d_sh[WIDTH-1:1]};
            bout  <= brw_nxt;
          end
        end
        default: begin
          if (accept) begin
            state <= ST_SHIFT;
            busy  <= 1'b1;
            cnt   <= '0;
            a_sh  <= a;
            b_sh  <= b;
            brw   <= bin;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed checks of serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int ref_diff(int ra, int rb, int rbin);
    return (ra - rb - rbin) & MASK;
  endfunction

  function automatic int ref_bout(int ra, int rb, int rbin);
    return (ra < rb + rbin) ? 1 : 0;
  endfunction

  function automatic int ref_ovf(int ra, int rb, int rbin);
    int d;
    int sa;
    int sb;
    int sd;
    d  = ref_diff(ra, rb, rbin);
    sa = (ra >> (W - 1)) & 1;
    sb = (rb >> (W - 1)) & 1;
    sd = (d >> (W - 1)) & 1;
    return ((sa != sb) && (sd != sa)) ? 1 : 0;
  endfunction

  // Present a request, let the edge accept it, and stop at the first negedge after acceptance.
  task automatic start_op(input int ra, input int rb, input int rbin, input bit hold);
    a     = W'(ra);
    b     = W'(rb);
    bin   = rbin[0];
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = hold;
    a     = W'($urandom);
    b     = W'($urandom);
    bin   = 1'($urandom);
  endtask

  // Walk the busy window and finish on the negedge where done is visible.
  task automatic expect_op(input int ra, input int rb, input int rbin, input int inject_at);
    for (int k = 1; k <= W; k++) begin
      chk("busy_window", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      if (k == inject_at) begin
        start = 1'b1;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
      end else if (inject_at > 0 && k == inject_at + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("diff", 32'(diff), 32'(ref_diff(ra, rb, rbin)));
    chk("bout", 32'(bout), 32'(ref_bout(ra, rb, rbin)));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("ovf", 32'(ovf), 32'(ref_ovf(ra, rb, rbin)));
`endif
  endtask

  task automatic after_done(input int ra, input int rb, input int rbin);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("diff_held", 32'(diff), 32'(ref_diff(ra, rb, rbin)));
    chk("bout_held", 32'(bout), 32'(ref_bout(ra, rb, rbin)));
  endtask

  task automatic single_op(input int ra, input int rb, input int rbin);
    start_op(ra, rb, rbin, 1'b0);
    expect_op(ra, rb, rbin, 0);
    after_done(ra, rb, rbin);
  endtask

  int ra;
  int rb;
  int rbin;
  int b2b_a[3] = '{15, 0, 9};
  int b2b_b[3] = '{15, 1, 12};
  int b2b_c[3] = '{0, 0, 1};
  int ovf_a[4] = '{8, 7, 3, 12};
  int ovf_b[4] = '{1, 1, 9, 4};
  int ovf_c[4] = '{0, 0, 0, 0};

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    single_op(7, 4, 0);
    single_op(3, 4, 0);
    single_op(5, 6, 1);
    single_op(0, 0, 1);
    single_op(15, 0, 0);

    // A second start while shifting must be ignored.
    start_op(9, 1, 0, 1'b0);
    expect_op(9, 1, 0, 1);
    after_done(9, 1, 0);
    chk("ignored_start_idle", 32'(busy), 32'd0);

    // Back-to-back with start held high through each DONE cycle.
    for (int i = 0; i < 3; i++) begin
      start_op(b2b_a[i], b2b_b[i], b2b_c[i], 1'b1);
      expect_op(b2b_a[i], b2b_b[i], b2b_c[i], 0);
    end
    start = 1'b0;
    after_done(b2b_a[2], b2b_b[2], b2b_c[2]);

    // Reset mid-operation aborts with no trailing done pulse.
    start_op(13, 2, 0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_bout", 32'(bout), 32'd0);
    for (int k = 0; k < W + 2; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_no_busy", 32'(busy), 32'd0);
    end
    single_op(6, 11, 0);

    for (int i = 0; i < 4; i++) single_op(ovf_a[i], ovf_b[i], ovf_c[i]);

    for (int i = 0; i < 40; i++) begin
      ra   = int'($urandom_range(MASK, 0));
      rb   = int'($urandom_range(MASK, 0));
      rbin = int'($urandom_range(1, 0));
      if ($urandom_range(1, 0) == 1) begin
        single_op(ra, rb, rbin);
      end else begin
        start_op(ra, rb, rbin, 1'b0);
        expect_op(ra, rb, rbin, int'($urandom_range(W - 1, 1)));
        start = 1'b0;
        after_done(ra, rb, rbin);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
